// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pkg : shared SPI mode/state types and CPOL/CPHA helpers          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package spi_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } spi_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } slv_state_e;

    function automatic logic cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : two-flop synchroniser for a bus of independent async bits |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/slv_spi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slv_spi : oversampled SPI target, all four modes, 1-deep tx holding  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module slv_spi
    import spi_pkg::*;
#(
    parameter int BUS = 4
) (
    input  logic           clk,
    input  logic           arst,
    input  logic [1:0]     mode,
    input  logic [BUS-1:0] tx_byte,
    input  logic           tx_vld,
    output logic           tx_rdy,
    output logic           tx_udr,
    output logic [BUS-1:0] rx_byte,
    output logic           rx_vld,
    input  logic           sclk,
    input  logic           ss_n,
    input  logic           mosi,
    output logic           miso
);

    localparam int             CW   = (BUS > 2) ? $clog2(BUS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(BUS - 1);

    logic [2:0]     w_sync;
    logic           w_ss_s;
    logic           w_sclk_s;
    logic           w_mosi_s;

    slv_state_e     state_q,   state_d;
    spi_mode_e      mode_q,    mode_d;
    logic           sclk_q;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BUS-1:0] tx_sr_q,   tx_sr_d;
    logic [BUS-2:0] rx_sr_q,   rx_sr_d;
    logic [BUS-1:0] hold_q,    hold_d;
    logic           tx_rdy_q,  tx_rdy_d;
    logic           tx_udr_q,  tx_udr_d;
    logic [BUS-1:0] rx_byte_q, rx_byte_d;
    logic           rx_vld_q,  rx_vld_d;

    logic           w_rise, w_fall, w_lead, w_trail;
    logic           w_sample, w_shift, w_load;
    logic [BUS-1:0] w_rx_next;

    sync_2ff #(
        .WIDTH   (3),
        .RST_VAL (3'b100)
    ) u_sync (
        .clk  (clk),
        .arst (arst),
        .d_i  ({ss_n, sclk, mosi}),
        .q_o  (w_sync)
    );

    assign {w_ss_s, w_sclk_s, w_mosi_s} = w_sync;

    assign w_rise    =  w_sclk_s & ~sclk_q;
    assign w_fall    = ~w_sclk_s &  sclk_q;
    assign w_lead    = cpol(mode_q) ? w_fall : w_rise;
    assign w_trail   = cpol(mode_q) ? w_rise : w_fall;
    assign w_sample  = cpha(mode_q) ? w_trail : w_lead;
    assign w_shift   = cpha(mode_q) ? w_lead  : w_trail;
    assign w_rx_next = {rx_sr_q, w_mosi_s};

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            mode_q    <= MODE0;
            sclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            hold_q    <= '0;
            tx_rdy_q  <= 1'b1;
            tx_udr_q  <= 1'b0;
            rx_byte_q <= '0;
            rx_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            sclk_q    <= w_sclk_s;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            hold_q    <= hold_d;
            tx_rdy_q  <= tx_rdy_d;
            tx_udr_q  <= tx_udr_d;
            rx_byte_q <= rx_byte_d;
            rx_vld_q  <= rx_vld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = w_ss_s ? spi_mode_e'(mode) : mode_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        hold_d    = hold_q;
        tx_rdy_d  = tx_rdy_q;
        tx_udr_d  = 1'b0;
        rx_byte_d = rx_byte_q;
        rx_vld_d  = 1'b0;
        w_load    = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                tx_sr_d   = '0;
                rx_sr_d   = '0;
                if (!w_ss_s) begin
                    state_d = ACTIVE;
                    w_load  = ~cpha(mode_q);
                end
            end
            ACTIVE: begin
                // Deselect wins over any sclk edge seen in the same cycle.
                if (w_ss_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    tx_sr_d   = '0;
                    rx_sr_d   = '0;
                end else begin
                    if (w_sample) begin
                        rx_sr_d = w_rx_next[BUS-2:0];
                        if (bit_cnt_q == LAST) begin
                            bit_cnt_d = '0;
                            rx_byte_d = w_rx_next;
                            rx_vld_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                    if (w_shift) begin
                        if (bit_cnt_q == '0) begin
                            w_load = 1'b1;
                        end else begin
                            tx_sr_d = tx_sr_q << 1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_load) begin
            tx_sr_d  = tx_rdy_q ? '0 : hold_q;
            tx_udr_d = tx_rdy_q;
            tx_rdy_d = 1'b1;
        end

        // Acceptance is judged on the pre-load flag, so a load in the same
        // cycle takes the old content and the new byte still gets captured.
        if (tx_vld && tx_rdy_q) begin
            hold_d   = tx_byte;
            tx_rdy_d = 1'b0;
        end
    end

    assign tx_rdy  = tx_rdy_q;
    assign tx_udr  = tx_udr_q;
    assign rx_byte = rx_byte_q;
    assign rx_vld  = rx_vld_q;
    assign miso    = (state_q == ACTIVE) & tx_sr_q[BUS-1];

endmodule
`default_nettype wire

// File: tb/tb_slv_spi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_slv_spi : bus-level SPI master driving slv_spi vs transaction model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_slv_spi;

    localparam int BUS = 4;
    localparam int H   = 4;

    logic           clk = 1'b0;
    logic           arst = 1'b1;
    logic [1:0]     mode = 2'b00;
    logic [BUS-1:0] tx_byte = '0;
    logic           tx_vld = 1'b0;
    logic           tx_rdy;
    logic           tx_udr;
    logic [BUS-1:0] rx_byte;
    logic           rx_vld;
    logic           sclk = 1'b0;
    logic           ss_n = 1'b1;
    logic           mosi = 1'b0;
    logic           miso;

    int n_checks = 0;
    int n_errors = 0;

    // transaction-level model of the slave
    bit             m_hold_vld = 1'b0;
    logic [BUS-1:0] m_hold     = '0;
    logic [BUS-1:0] m_last_rx  = '0;

    logic [BUS-1:0] rx_seen[$];
    int             udr_cnt = 0;

    slv_spi #(.BUS(BUS)) dut (
        .clk     (clk),
        .arst    (arst),
        .mode    (mode),
        .tx_byte (tx_byte),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .tx_udr  (tx_udr),
        .rx_byte (rx_byte),
        .rx_vld  (rx_vld),
        .sclk    (sclk),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!arst) begin
            if (rx_vld) rx_seen.push_back(rx_byte);
            if (tx_udr) udr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [BUS-1:0] d);
        chk("tx_rdy_before_push", 32'(tx_rdy), 32'(!m_hold_vld));
        tx_byte = d;
        tx_vld  = 1'b1;
        tick(1);
        tx_vld  = 1'b0;
        if (!m_hold_vld) begin
            m_hold     = d;
            m_hold_vld = 1'b1;
        end
        tick(1);
        chk("tx_rdy_after_push", 32'(tx_rdy), 32'(!m_hold_vld));
    endtask

    task automatic master_frame(input logic [1:0] m, input logic [BUS-1:0] d,
                                input int nbits, input bit last,
                                output logic [BUS-1:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!m[0]) begin
                mosi = d[BUS-1-i];
                tick(H);
                got[BUS-1-i] = miso;
                sclk = ~m[1];
                tick(H);
                sclk = m[1];
                if (last && i == nbits-1) ss_n = 1'b1;
            end else begin
                tick(H);
                sclk = ~m[1];
                mosi = d[BUS-1-i];
                tick(H);
                got[BUS-1-i] = miso;
                sclk = m[1];
                if (last && i == nbits-1) begin
                    tick(H);
                    ss_n = 1'b1;
                end
            end
        end
    endtask

    // One ss_n-low window of nf frames; a non-zero abort cuts the last frame short.
    task automatic window(input logic [1:0] m, input int nf,
                          input logic [3*BUS-1:0] data, input int abort);
        logic [BUS-1:0] got;
        logic [BUS-1:0] exp_tx;
        logic [BUS-1:0] exp_rx[$];
        int             exp_udr;
        int             nbits;
        exp_udr = 0;
        mode = m;
        sclk = m[1];
        tick(6);
        rx_seen.delete();
        udr_cnt = 0;
        ss_n = 1'b0;
        for (int i = 0; i < nf; i++) begin
            nbits = (i == nf-1 && abort > 0) ? abort : BUS;
            exp_tx = m_hold_vld ? m_hold : '0;
            if (!m_hold_vld) exp_udr++;
            m_hold_vld = 1'b0;
            master_frame(m, data[BUS*i +: BUS], nbits, i == nf-1, got);
            if (nbits == BUS) begin
                chk("miso_frame", 32'(got), 32'(exp_tx));
                exp_rx.push_back(data[BUS*i +: BUS]);
                m_last_rx = data[BUS*i +: BUS];
            end
        end
        tick(8);
        chk("rx_vld_count", 32'(rx_seen.size()), 32'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < rx_seen.size(); i++)
            chk("rx_byte_seq", 32'(rx_seen[i]), 32'(exp_rx[i]));
        chk("tx_udr_count", 32'(udr_cnt), 32'(exp_udr));
        chk("rx_byte_hold", 32'(rx_byte), 32'(m_last_rx));
        chk("tx_rdy_end", 32'(tx_rdy), 32'(!m_hold_vld));
        chk("miso_idle", 32'(miso), 32'd0);
    endtask

    initial begin
        logic [BUS-1:0] got;
        tick(4);
        chk("rst_tx_rdy", 32'(tx_rdy), 32'd1);
        chk("rst_tx_udr", 32'(tx_udr), 32'd0);
        chk("rst_rx_vld", 32'(rx_vld), 32'd0);
        chk("rst_rx_byte", 32'(rx_byte), 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);
        arst = 1'b0;
        tick(4);

        push(4'b1101);
        window(2'd0, 1, 12'h00A, 0);
        for (int m = 1; m < 4; m++) begin
            push(4'h3);
            window(2'(m), 1, 12'h005, 0);
        end

        push(4'h9);
        window(2'd0, 2, 12'h06A, 0);

        window(2'd0, 1, 12'h00B, 2);
        window(2'd0, 1, 12'h00C, 0);

        // asynchronous reset in the middle of a frame
        push(4'h5);
        mode = 2'd0;
        sclk = 1'b0;
        tick(6);
        ss_n = 1'b0;
        master_frame(2'd0, 4'h6, 2, 1'b0, got);
        tick(1);
        #2;
        arst = 1'b1;
        #1;
        chk("arst_tx_rdy", 32'(tx_rdy), 32'd1);
        chk("arst_tx_udr", 32'(tx_udr), 32'd0);
        chk("arst_rx_vld", 32'(rx_vld), 32'd0);
        chk("arst_rx_byte", 32'(rx_byte), 32'd0);
        chk("arst_miso", 32'(miso), 32'd0);
        m_hold_vld = 1'b0;
        m_last_rx  = '0;
        tick(2);
        arst = 1'b0;
        ss_n = 1'b1;
        tick(4);
        window(2'd0, 1, 12'h009, 0);

        push(4'h7);
        push(4'h2);
        window(2'd0, 1, 12'h003, 0);

        for (int r = 0; r < 24; r++) begin
            logic [1:0]       rm;
            int               nf;
            int               ab;
            logic [3*BUS-1:0] rd;
            rm = 2'($urandom_range(0, 3));
            nf = int'($urandom_range(1, 3));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, BUS-1)) : 0;
            rd = 12'($urandom);
            if ($urandom_range(0, 1) == 1) push(4'($urandom));
            if ($urandom_range(0, 3) == 0) push(4'($urandom));
            window(rm, nf, rd, ab);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
